ysyx_22050612_regfile_sb: RTL

Parametrised integer register file with a built-in write-back scoreboard, for the pipelined NPC core.
- Provides NREAD combinational read ports and NWRITE write ports, with write-to-read bypass.
- Register 0 is hardwired to zero.
- Keeps a per-register pending-write counter: the issue stage reserves a destination, the write-back stage releases it, and read ports report whether their operand is still outstanding.
- Sits between decode/issue (read and reserve) and write-back (write and release).

---
 rtl/ysyx_22050612_regfile_sb_pkg.sv | 17 +
 rtl/ysyx_22050612_regfile_sb_counter.sv | 53 +++++
 rtl/ysyx_22050612_regfile_sb.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ysyx_22050612_regfile_sb_pkg.sv
// Shared constants for the NPC register file and its write-back scoreboard.
package ysyx_22050612_regfile_sb_pkg;

    // Default geometry of the NPC integer register file.
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_CNT_WIDTH  = 2;

    // Index of the hardwired-zero register.
    localparam int ZERO_REG = 0;

    // Width needed to count 0..n simultaneous events.
    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ysyx_22050612_regfile_sb_counter.sv
// Saturating up/down pending-write counter for one register.
// A net decrement past zero clamps at zero and raises a one-cycle underflow strobe.
// Flush clears the counter and discards that cycle's increment and decrements.
import ysyx_22050612_regfile_sb_pkg::*;

module ysyx_22050612_sb_counter #(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int DEC_W     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic [DEC_W-1:0]     dec_count,
    input  logic                 flush,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 at_max,
    output logic                 underflow
);

    localparam int MAX = (1 << CNT_WIDTH) - 1;

    logic [CNT_WIDTH-1:0] count_next;
    int                   sum;

    // Next count: net of one reserve and any number of releases, clamped both ways.
    always_comb begin
        sum        = int'(count) + int'(inc) - int'(dec_count);
        underflow  = 1'b0;
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (sum < 0) begin
            count_next = '0;
            underflow  = 1'b1;
        end else if (sum > MAX) begin
            count_next = CNT_WIDTH'(MAX);
        end else begin
            count_next = CNT_WIDTH'(sum);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    assign at_max = (count == CNT_WIDTH'(MAX));

endmodule

// File: rtl/ysyx_22050612_regfile_sb.sv
// Integer register file with write-to-read bypass and a per-register
// pending-write scoreboard (reserve at issue, release at write-back).
// Reservation handshake: a reserve fires when rsv_valid && rsv_ready;
// rsv_ready never depends on rsv_valid, and rsv_valid may be held or dropped freely.
import ysyx_22050612_regfile_sb_pkg::*;

module ysyx_22050612_regfile_sb #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NREAD      = 2,
    parameter int NWRITE     = 1,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NWRITE-1:0]           wen,
    input  logic [NWRITE*ADDR_WIDTH-1:0] waddr,
    input  logic [NWRITE*DATA_WIDTH-1:0] wdata,
    input  logic [NWRITE-1:0]           wrel,
    input  logic [NREAD*ADDR_WIDTH-1:0] raddr,
    output logic [NREAD*DATA_WIDTH-1:0] rdata,
    output logic [NREAD-1:0]            rbusy,
    input  logic                        rsv_valid,
    input  logic [ADDR_WIDTH-1:0]       rsv_addr,
    output logic                        rsv_ready,
    input  logic                        flush,
    output logic                        sb_err
);

    localparam int NREGS = 1 << ADDR_WIDTH;
    localparam int DEC_W = count_width(NWRITE);
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

    logic [DATA_WIDTH-1:0] rf      [NREGS];
    logic [CNT_WIDTH-1:0]  cnt     [NREGS];
    logic [DEC_W-1:0]      rel_cnt [NREGS];
    logic [NREGS-1:0]      at_max;
    logic [NREGS-1:0]      underflow;
    logic                  rsv_fire;

    // Number of write-back ports releasing each register this cycle.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            rel_cnt[r] = '0;
            for (int i = 0; i < NWRITE; i++) begin
                if (wrel[i] && (waddr[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))) begin
                    rel_cnt[r] = rel_cnt[r] + DEC_W'(1);
                end
            end
        end
    end

    // A full counter can still accept a reserve when a release lands the same cycle.
    assign rsv_ready = (rsv_addr == ZERO_IDX) || !at_max[rsv_addr] || (rel_cnt[rsv_addr] != '0);
    assign rsv_fire  = rsv_valid && rsv_ready;

    // Register 0 has no counter: never busy, never full, never underflows.
    assign cnt[0]       = '0;
    assign at_max[0]    = 1'b0;
    assign underflow[0] = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_cnt
        ysyx_22050612_sb_counter #(
            .CNT_WIDTH (CNT_WIDTH),
            .DEC_W     (DEC_W)
        ) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc       (rsv_fire && (rsv_addr == ADDR_WIDTH'(r))),
            .dec_count (rel_cnt[r]),
            .flush     (flush),
            .count     (cnt[r]),
            .at_max    (at_max[r]),
            .underflow (underflow[r])
        );
    end

    // Sticky scoreboard error: any release against an empty counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_err <= 1'b0;
        end else if (|underflow) begin
            sb_err <= 1'b1;
        end
    end

    // Storage: ports applied in ascending order so the highest index wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                rf[r] <= '0;
            end
        end else begin
            for (int i = 0; i < NWRITE; i++) begin
                if (wen[i] && (waddr[i*ADDR_WIDTH +: ADDR_WIDTH] != ZERO_IDX)) begin
                    rf[waddr[i*ADDR_WIDTH +: ADDR_WIDTH]] <= wdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    for (genvar j = 0; j < NREAD; j++) begin : g_read
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;
        logic                  busy;

        assign ra = raddr[j*ADDR_WIDTH +: ADDR_WIDTH];

        // Read mux with bypass from the highest matching write port, plus busy status.
        always_comb begin
            rd = rf[ra];
            for (int i = 0; i < NWRITE; i++) begin
                if (wen[i] && (waddr[i*ADDR_WIDTH +: ADDR_WIDTH] == ra)) begin
                    rd = wdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (ra == ZERO_IDX) begin
                rd = '0;
            end
            busy = (ra != ZERO_IDX) && (int'(cnt[ra]) > int'(rel_cnt[ra]));
        end

        assign rdata[j*DATA_WIDTH +: DATA_WIDTH] = rd;
        assign rbusy[j]                          = busy;
    end

endmodule
